// File: rtl/button_events.sv
// Turns debounced push-button edges into single-cycle UI events: short press,
// double click, long press, auto-repeat while held, plus a held level.
module button_events #(
  parameter int unsigned LONG_CYCLES    = 50_000_000,
  parameter int unsigned DBL_GAP_CYCLES = 15_000_000,
  parameter int unsigned REPEAT_CYCLES  = 5_000_000,
  parameter int unsigned CNT_W          = 26
) (
  input  logic clk50m,
  input  logic rst_n,
  input  logic sw_dbnc,
  input  logic sw_hi,
  input  logic sw_lo,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic repeat_evt,
  output logic held
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_WAIT2,
    S_PRESS2,
    S_LONG,
    S_LOCKOUT
  } state_t;

  // cnt_q holds k-1 on the edge being evaluated, so thresholds compare against N-1.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_press_q, short_press_d;
  logic             double_click_q, double_click_d;
  logic             long_press_q, long_press_d;
  logic             repeat_evt_q, repeat_evt_d;
  logic             held_q, held_d;
  logic             ev_hi, ev_lo;

  always_comb begin
    ev_hi          = sw_hi & ~sw_lo;
    ev_lo          = sw_lo & ~sw_hi;
    state_d        = state_q;
    cnt_d          = cnt_q + CNT_ONE;
    short_press_d  = 1'b0;
    double_click_d = 1'b0;
    long_press_d   = 1'b0;
    repeat_evt_d   = 1'b0;
    held_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (ev_hi) begin
          state_d = S_PRESS1;
        end else if (sw_dbnc && !sw_hi) begin
          state_d = S_LOCKOUT;
        end
      end

      S_PRESS1: begin
        if (ev_lo) begin
          state_d = S_WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d      = S_LONG;
          cnt_d        = '0;
          long_press_d = 1'b1;
          held_d       = 1'b1;
        end
      end

      S_LONG: begin
        held_d = 1'b1;
        if (ev_lo) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          held_d  = 1'b0;
        end else if (cnt_q == REP_LAST) begin
          repeat_evt_d = 1'b1;
          cnt_d        = '0;
        end
      end

      S_WAIT2: begin
        if (ev_hi) begin
          state_d = S_PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d       = S_IDLE;
          cnt_d         = '0;
          short_press_d = 1'b1;
        end
      end

      S_PRESS2: begin
        if (ev_lo) begin
          state_d        = S_IDLE;
          cnt_d          = '0;
          double_click_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = S_LOCKOUT;
          cnt_d   = '0;
        end
      end

      S_LOCKOUT: begin
        cnt_d = '0;
        if (ev_lo) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      short_press_q  <= 1'b0;
      double_click_q <= 1'b0;
      long_press_q   <= 1'b0;
      repeat_evt_q   <= 1'b0;
      held_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      short_press_q  <= short_press_d;
      double_click_q <= double_click_d;
      long_press_q   <= long_press_d;
      repeat_evt_q   <= repeat_evt_d;
      held_q         <= held_d;
    end
  end

  assign short_press  = short_press_q;
  assign double_click = double_click_q;
  assign long_press   = long_press_q;
  assign repeat_evt   = repeat_evt_q;
  assign held         = held_q;

endmodule
